// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//
// Actuated two-road phase scheduler. The main road rests in green; latched
// side-street vehicle or pedestrian demand starts a full cycle:
// main yellow -> all-red -> side green -> side yellow -> all-red -> main green.
// An emergency preempt forces the side green to end immediately (the
// clearance intervals still run in full). If the preempt is active when the
// first all-red ends, right-of-way returns to the main road.
//
// Light encoding: 00 red, 01 yellow, 10 green (11 never driven).
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   side_car    side-street vehicle detector (level)
//   ped_req     pedestrian push-button (pulse or level)
//   emerg       emergency preempt (level)
//   main_light  main-road head
//   side_light  side-street head
//   walk        pedestrian walk indication
//   phase       current state code (debug)
//
// state       | code | meaning
// ------------+------+------------------------------------------
// MAIN_GREEN  |  0   | rest state, main green, waits for demand
// MAIN_YELLOW |  1   | main yellow clearance
// ALLRED_A    |  2   | all-red before side green (preempt check)
// SIDE_GREEN  |  3   | side green, SIDE_MIN..SIDE_MAX cycles
// SIDE_YELLOW |  4   | side yellow clearance
// ALLRED_B    |  5   | all-red before returning to main green

module traffic_phase_scheduler #(
    parameter int TW       = 8,
    parameter int MAIN_MIN = 6,
    parameter int YELLOW   = 3,
    parameter int ALL_RED  = 2,
    parameter int SIDE_MIN = 4,
    parameter int SIDE_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       side_car,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [1:0] main_light,
    output logic [1:0] side_light,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALLRED_A    = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALLRED_B    = 3'd5
    } state_t;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    // A state of duration D exits on the edge where timer == D-1.
    localparam logic [TW-1:0] MAIN_MIN_M1 = TW'(MAIN_MIN - 1);
    localparam logic [TW-1:0] YELLOW_M1   = TW'(YELLOW - 1);
    localparam logic [TW-1:0] ALL_RED_M1  = TW'(ALL_RED - 1);
    localparam logic [TW-1:0] SIDE_MIN_M1 = TW'(SIDE_MIN - 1);
    localparam logic [TW-1:0] SIDE_MAX_M1 = TW'(SIDE_MAX - 1);
    localparam logic [TW-1:0] TIMER_MAX   = '1;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic          car_pend;
    logic          ped_pend;
    logic          ped_served;
    logic          demand;
    logic          enter_side;
    logic          leave_side;

    assign demand     = car_pend | ped_pend;
    assign enter_side = (state_next == SIDE_GREEN) && (state != SIDE_GREEN);
    assign leave_side = (state == SIDE_GREEN) && (state_next != SIDE_GREEN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= MAIN_GREEN;
            timer      <= '0;
            car_pend   <= 1'b0;
            ped_pend   <= 1'b0;
            ped_served <= 1'b0;
        end else begin
            state <= state_next;

            if (state_next != state) begin
                timer <= '0;
            end else if (timer != TIMER_MAX) begin
                timer <= timer + 1'b1;
            end

            // Entering side green serves every request seen so far,
            // including one sampled on that same edge.
            if (enter_side) begin
                car_pend <= 1'b0;
                ped_pend <= 1'b0;
            end else begin
                car_pend <= car_pend | side_car;
                ped_pend <= ped_pend | ped_req;
            end

            if (enter_side) begin
                ped_served <= ped_pend | ped_req;
            end else if (leave_side) begin
                ped_served <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MAIN_GREEN: begin
                // emerg has priority over demand: stay on main green.
                if ((timer >= MAIN_MIN_M1) && demand && !emerg) begin
                    state_next = MAIN_YELLOW;
                end
            end
            MAIN_YELLOW: begin
                if (timer == YELLOW_M1) begin
                    state_next = ALLRED_A;
                end
            end
            ALLRED_A: begin
                // Preempt skips the side phase; latches stay pending.
                if (timer == ALL_RED_M1) begin
                    state_next = emerg ? MAIN_GREEN : SIDE_GREEN;
                end
            end
            SIDE_GREEN: begin
                if (emerg || ((timer >= SIDE_MIN_M1) && !side_car) ||
                    (timer == SIDE_MAX_M1)) begin
                    state_next = SIDE_YELLOW;
                end
            end
            SIDE_YELLOW: begin
                if (timer == YELLOW_M1) begin
                    state_next = ALLRED_B;
                end
            end
            ALLRED_B: begin
                if (timer == ALL_RED_M1) begin
                    state_next = MAIN_GREEN;
                end
            end
            default: begin
                state_next = MAIN_GREEN;
            end
        endcase
    end

    always_comb begin
        main_light = LIGHT_RED;
        side_light = LIGHT_RED;
        case (state)
            MAIN_GREEN:  main_light = LIGHT_GREEN;
            MAIN_YELLOW: main_light = LIGHT_YELLOW;
            SIDE_GREEN:  side_light = LIGHT_GREEN;
            SIDE_YELLOW: side_light = LIGHT_YELLOW;
            default: begin
                main_light = LIGHT_RED;
                side_light = LIGHT_RED;
            end
        endcase
    end

    assign walk  = (state == SIDE_GREEN) && ped_served;
    assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler with default parameters: directed
// scenarios with fixed expected timelines, then randomized inputs checked
// every cycle against a phase/duration-table reference model.

module tb_traffic_phase_scheduler;

    localparam int MAIN_MIN = 6;
    localparam int YELLOW   = 3;
    localparam int ALL_RED  = 2;
    localparam int SIDE_MIN = 4;
    localparam int SIDE_MAX = 8;
    localparam int T_SAT    = 255;

    logic       clk;
    logic       rst_n;
    logic       side_car;
    logic       ped_req;
    logic       emerg;
    logic [1:0] main_light;
    logic [1:0] side_light;
    logic       walk;
    logic [2:0] phase;

    int n_total;
    int n_bad;
    int cyc;

    // reference model state
    int m_ph;
    int m_t;
    bit m_car;
    bit m_ped;
    bit m_served;

    int dur[6]      = '{MAIN_MIN, YELLOW, ALL_RED, SIDE_MIN, YELLOW, ALL_RED};
    int exp_main[6] = '{2, 1, 0, 0, 0, 0};
    int exp_side[6] = '{0, 0, 0, 2, 1, 0};

    traffic_phase_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .side_car   (side_car),
        .ped_req    (ped_req),
        .emerg      (emerg),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .phase      (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int expv);
        n_total++;
        if (obs != expv) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, cyc, obs, expv);
        end
    endtask

    task automatic model_step(input bit r, input bit c, input bit p, input bit e);
        int  nxt;
        bit  done;
        if (!r) begin
            m_ph = 0; m_t = 0; m_car = 0; m_ped = 0; m_served = 0;
            return;
        end
        done = (m_t + 1 >= dur[m_ph]);
        nxt  = m_ph;
        case (m_ph)
            0: if (done && (m_car || m_ped) && !e) nxt = 1;
            2: if (done) nxt = e ? 0 : 3;
            3: if (e || (done && !c) || (m_t + 1 >= SIDE_MAX)) nxt = 4;
            default: if (done) nxt = (m_ph + 1) % 6;
        endcase
        if (nxt == 3 && m_ph != 3) begin
            m_served = m_ped | p;
            m_car    = 0;
            m_ped    = 0;
        end else begin
            m_car = m_car | c;
            m_ped = m_ped | p;
            if (m_ph == 3 && nxt != 3) m_served = 0;
        end
        m_t  = (nxt != m_ph) ? 0 : ((m_t < T_SAT) ? m_t + 1 : T_SAT);
        m_ph = nxt;
    endtask

    task automatic check_all();
        check_val("phase", int'(phase), m_ph);
        check_val("main", int'(main_light), exp_main[m_ph]);
        check_val("side", int'(side_light), exp_side[m_ph]);
        check_val("walk", int'(walk), (m_ph == 3 && m_served) ? 1 : 0);
        check_val("mutex", int'(main_light != 2'b00 && side_light != 2'b00), 0);
    endtask

    // Drive one cycle of inputs, take the edge, then check at the negedge.
    task automatic step(input bit r, input bit c, input bit p, input bit e);
        rst_n    = r;
        side_car = c;
        ped_req  = p;
        emerg    = e;
        @(posedge clk);
        model_step(r, c, p, e);
        @(negedge clk);
        cyc = r ? cyc + 1 : 0;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    function automatic int plan_a(input int k);
        if (k < 6)  return 0;
        if (k < 9)  return 1;
        if (k < 11) return 2;
        if (k < 15) return 3;
        if (k < 18) return 4;
        if (k < 20) return 5;
        return 0;
    endfunction

    initial begin
        int walk_cnt;
        int side_entries;
        int prev_ph;
        int busy_cnt;
        bit em_lvl;

        n_total  = 0;
        n_bad    = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        side_car = 1'b0;
        ped_req  = 1'b0;
        emerg    = 1'b0;

        // reset state and idle rest
        do_reset();
        check_val("rst_phase", int'(phase), 0);
        check_val("rst_main", int'(main_light), 2);
        for (int k = 0; k < 100; k++) step(1, 0, 0, 0);
        check_val("idle_phase", int'(phase), 0);
        check_val("idle_side", int'(side_light), 0);

        // side_car pulse at cycle 2: fixed timeline
        do_reset();
        for (int k = 0; k < 25; k++) begin
            step(1, cyc == 2, 0, 0);
            check_val("plan_a", int'(phase), plan_a(cyc));
            check_val("plan_a_walk", int'(walk), 0);
        end

        // side_car held: side green capped at SIDE_MAX, fresh cycle follows
        do_reset();
        busy_cnt = 0;
        for (int k = 0; k < 31; k++) begin
            step(1, 1, 0, 0);
            if (phase == 3'd3) busy_cnt++;
            if (cyc == 11) check_val("held_sg_start", int'(phase), 3);
            if (cyc == 19) check_val("held_sy", int'(phase), 4);
            if (cyc == 24) check_val("held_mg", int'(phase), 0);
            if (cyc == 30) check_val("held_again", int'(phase), 1);
        end
        check_val("held_sg_len", busy_cnt, 8);

        // pedestrian pulse at 30, second press during side green at 38
        do_reset();
        walk_cnt     = 0;
        side_entries = 0;
        prev_ph      = 0;
        for (int k = 0; k < 120; k++) begin
            step(1, 0, (cyc == 30) || (cyc == 38), 0);
            if (walk) walk_cnt++;
            if (phase == 3'd3 && prev_ph != 3) side_entries++;
            prev_ph = int'(phase);
            if (cyc == 37) check_val("ped_walk37", int'(walk), 1);
            if (cyc == 41) check_val("ped_walk41", int'(walk), 0);
            if (cyc == 57) check_val("ped_walk57", int'(walk), 1);
        end
        check_val("ped_walk_cnt", walk_cnt, 8);
        check_val("ped_side_cnt", side_entries, 2);

        // emergency during side green, demand pending while preempt held
        do_reset();
        for (int k = 0; k < 45; k++) begin
            step(1, (cyc == 2) || (cyc == 14), 0, (cyc >= 12) && (cyc < 40));
            if (cyc == 13) check_val("em_side_y", int'(side_light), 1);
            if (cyc == 16) check_val("em_allred", int'(phase), 5);
            if (cyc == 30) check_val("em_hold30", int'(phase), 0);
            if (cyc == 40) check_val("em_hold40", int'(phase), 0);
            if (cyc == 41) check_val("em_release", int'(phase), 1);
        end

        // reset mid side green drops pending demand
        do_reset();
        for (int k = 0; k < 13; k++) step(1, cyc == 2, cyc == 12, 0);
        check_val("mid_pre", int'(phase), 3);
        step(0, 1, 1, 0);
        check_val("mid_phase", int'(phase), 0);
        check_val("mid_main", int'(main_light), 2);
        check_val("mid_walk", int'(walk), 0);
        rst_n = 1'b1;
        busy_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step(1, 0, 0, 0);
            if (phase != 3'd0) busy_cnt++;
        end
        check_val("mid_lost", busy_cnt, 0);

        // randomized run against the model
        do_reset();
        em_lvl = 0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(39) == 0) em_lvl = !em_lvl;
            step($urandom_range(499) != 0,
                 $urandom_range(7) == 0,
                 $urandom_range(15) == 0,
                 em_lvl);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
